demux_stream_1ton: RTL and testbench
====================================

Name: demux_stream_1toN

Overview:
- Parametrised, registered successor to the 1-to-8 gate-level demultiplexer.
- Routes a DW-bit data stream from one valid/ready input to one of N valid/ready output channels.
- Each output channel has a one-entry output register, so a stalled channel does not block traffic to other channels.
- Two routing modes:
  - addressed (select input);
  - round-robin (internal pointer).
- Sits between a single producer and N independent consumers in the datapath experiments.

Parameters:
- DW, 8, data width in bits, at least 1.
- N, 8, number of output channels, 2..16.
- SW, 3, select/pointer width; must satisfy 2^SW >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  DW  input word.
- sel  input  SW  destination channel in addressed mode; ignored in round-robin mode.
- mode  input  1  0 = addressed, 1 = round-robin.
- out_valid  output  N  per-channel valid; bit k is channel k.
- out_ready  input  N  per-channel consumer ready.
- out_data  output  N*DW  channel k occupies bits [k*DW +: DW].
- rr_ptr  output  SW  current round-robin target.
- err_cnt  output  8  count of words dropped for an out-of-range sel.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst high at a clk edge; dominates all other inputs):
  - out_valid = 0, out_data = 0, rr_ptr = 0, err_cnt = 0.
  - Words held in channel registers are discarded.
  - in_ready is low during any cycle in which rst is high.
- Target selection: tgt = sel when mode = 0; tgt = rr_ptr when mode = 1. The mode is sampled in the same cycle as in_valid.
- Channel k slot state:
  - empty when out_valid[k] = 0;
  - draining when out_valid[k] = 1 and out_ready[k] = 1.
- in_ready (combinational from current state and inputs; it does not depend on in_valid):
  - 1 when tgt < N and channel tgt is empty or draining;
  - 1 when tgt >= N (the word will be dropped);
  - otherwise 0.
- Transfer occurs at a clk edge when in_valid and in_ready are both high.
  - tgt < N: out_data[tgt] <= in_data and out_valid[tgt] <= 1. The word appears on the channel the cycle after acceptance (latency 1).
  - tgt >= N (only possible when N < 2^SW): the word is discarded and err_cnt increments, saturating at 255. No channel changes.
- Channel drain: with out_valid[k] = 1 and out_ready[k] = 1, and no new transfer into k in that cycle, out_valid[k] <= 0. out_data[k] holds its last value.
- Simultaneous drain and refill of the same channel: both occur. out_valid[k] stays 1 and out_data[k] takes the new word. Full throughput of 1 word/cycle into one channel whose consumer is always ready.
- Independence: channels drain concurrently. A stalled channel j blocks only transfers whose tgt = j.
- Output stability: while out_valid[k] = 1 and out_ready[k] = 0, out_data[k] must not change.
- Round-robin pointer:
  - Advances only on a transfer while mode = 1: rr_ptr <= (rr_ptr == N-1) ? 0 : rr_ptr + 1.
  - Holds when mode = 0 and when no transfer occurs.
  - Never takes values >= N.
- Round-robin stall: in mode 1 the block waits on rr_ptr's channel even if other channels are empty; there is no skipping.
- Mode switch: takes effect on the next cycle's target calculation. Already-buffered words are unaffected.
- Reset in mid-stream: buffered words are lost, and the consumer sees out_valid fall to 0 the cycle after rst is sampled.
- Combinational paths: no path from out_ready to out_data. The only path from out_ready[tgt] is to in_ready.

Test Plan:
- Addressed sweep, N=8, DW=8, all out_ready = 1: send 0xA0..0xA7 with sel = 0..7 back-to-back. Expect out_valid one-hot on channel k the cycle after acceptance, data 0xA0+k, and in_ready constantly 1.
- Backpressure: out_ready[3] = 0. Send 0x11 then 0x22, both with sel = 3.
  - 0x11 is accepted; in_ready drops to 0 for the second word.
  - out_data[3] holds 0x11.
  - Raise out_ready[3]: 0x22 is accepted in the same cycle, and out_valid[3] stays 1 with data 0x22 next cycle.
- Independence: hold channel 3 full and stalled. Send sel = 5 with data 0x55. Expect it accepted immediately and out_valid[5] = 1 next cycle.
- Round-robin: mode = 1, all ready. Send 10 words 0x00..0x09. Expect channel order 0,1,…,7,0,1, with rr_ptr wrapping 7→0 after the 8th word. Then set mode = 0 and send 1 word: rr_ptr holds at 2.
- Out-of-range, N=6, SW=3: send sel = 6 and sel = 7 with in_valid = 1. Expect in_ready = 1, no out_valid change, and err_cnt = 2. Drive 300 out-of-range words: err_cnt saturates at 255.
- Reset mid-operation: fill channels 1 and 4 with out_ready = 0 and rr_ptr = 3, then pulse rst for one cycle. Expect out_valid = 0, out_data = 0, rr_ptr = 0, err_cnt = 0 the next cycle, and in_ready = 0 during the rst cycle.

Source files
------------

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer: one valid/ready producer fanned out to N
// independent valid/ready consumers, each with its own one-entry output register.
module demux_stream_1ton #(
    parameter int DW = 8,
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N*DW-1:0] out_data,
    output logic [SW-1:0]   rr_ptr,
    output logic [7:0]      err_cnt
);

    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    logic [SW-1:0]        tgt;
    logic [N-1:0]         tgt_hit;
    logic                 in_range;
    logic                 tgt_free;
    logic                 accept;
    logic [N-1:0]         load;
    logic [N-1:0][DW-1:0] data_q;

    // An out-of-range target decodes to no channel, so it is always "free" and gets dropped.
    always_comb begin
        tgt     = mode ? rr_ptr : sel;
        tgt_hit = '0;
        for (int k = 0; k < N; k++) begin
            tgt_hit[k] = (tgt == SW'(k));
        end
        in_range = |tgt_hit;
        tgt_free = |(tgt_hit & (~out_valid | out_ready));
        in_ready = !rst && (!in_range || tgt_free);
        accept   = in_valid && in_ready;
        load     = tgt_hit & {N{accept}};
    end

    assign out_data = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            data_q    <= '0;
            rr_ptr    <= '0;
            err_cnt   <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    out_valid[k] <= 1'b1;
                    data_q[k]    <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end

            if (accept && !in_range && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (accept && mode) begin
                rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: an N=8 and an N=6 instance share one stimulus stream
// and are each compared every cycle against a channel-array reference model.
module tb_demux_stream_1ton;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [2:0]  sel;
    logic        mode;
    logic [7:0]  out_ready;

    logic        in_ready8, in_ready6;
    logic [7:0]  out_valid8;
    logic [5:0]  out_valid6;
    logic [63:0] out_data8;
    logic [47:0] out_data6;
    logic [2:0]  rr_ptr8, rr_ptr6;
    logic [7:0]  err8, err6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_stream_1ton #(.DW(8), .N(8), .SW(3)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .sel(sel), .mode(mode), .out_valid(out_valid8),
        .out_ready(out_ready), .out_data(out_data8), .rr_ptr(rr_ptr8), .err_cnt(err8)
    );

    demux_stream_1ton #(.DW(8), .N(6), .SW(3)) u6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
        .in_data(in_data), .sel(sel), .mode(mode), .out_valid(out_valid6),
        .out_ready(out_ready[5:0]), .out_data(out_data6), .rr_ptr(rr_ptr6), .err_cnt(err6)
    );

    // Reference model, index 0 = N8 instance, index 1 = N6 instance.
    int         nch[2] = '{8, 6};
    bit         mv[2][8];
    logic [7:0] md[2][8];
    int         mptr[2];
    int         merr[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int target(int i);
        return mode ? mptr[i] : int'(sel);
    endfunction

    function automatic bit exp_ready(int i);
        int t;
        t = target(i);
        if (rst) return 1'b0;
        if (t >= nch[i]) return 1'b1;
        return !mv[i][t] || out_ready[t];
    endfunction

    task automatic model_update(int i, bit rdy);
        int  t;
        bit  acc;
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                mv[i][k] = 0;
                md[i][k] = 8'h00;
            end
            mptr[i] = 0;
            merr[i] = 0;
            return;
        end
        t   = target(i);
        acc = in_valid && rdy;
        for (int k = 0; k < nch[i]; k++) begin
            if (acc && t == k) begin
                mv[i][k] = 1;
                md[i][k] = in_data;
            end else if (out_ready[k]) begin
                mv[i][k] = 0;
            end
        end
        if (acc && t >= nch[i] && merr[i] < 255) merr[i] = merr[i] + 1;
        if (acc && mode) mptr[i] = (mptr[i] + 1) % nch[i];
    endtask

    task automatic compare_outputs();
        logic [63:0] ev[2];
        logic [63:0] ed[2];
        for (int i = 0; i < 2; i++) begin
            ev[i] = '0;
            ed[i] = '0;
            for (int k = 0; k < nch[i]; k++) begin
                ev[i][k]       = mv[i][k];
                ed[i][k*8 +: 8] = md[i][k];
            end
        end
        check("out_valid8", 64'(out_valid8), ev[0]);
        check("out_data8",  64'(out_data8),  ed[0]);
        check("rr_ptr8",    64'(rr_ptr8),    64'(mptr[0]));
        check("err_cnt8",   64'(err8),       64'(merr[0]));
        check("out_valid6", 64'(out_valid6), ev[1]);
        check("out_data6",  64'(out_data6),  ed[1]);
        check("rr_ptr6",    64'(rr_ptr6),    64'(mptr[1]));
        check("err_cnt6",   64'(err6),       64'(merr[1]));
    endtask

    // Inputs are already driven; check in_ready mid-cycle, clock, then check outputs.
    task automatic cyc();
        bit er[2];
        #2;
        er[0] = exp_ready(0);
        er[1] = exp_ready(1);
        check("in_ready8", 64'(in_ready8), 64'(er[0]));
        check("in_ready6", 64'(in_ready6), 64'(er[1]));
        @(posedge clk);
        model_update(0, er[0]);
        model_update(1, er[1]);
        #1;
        compare_outputs();
    endtask

    task automatic send(input bit v, input logic [2:0] s, input logic [7:0] d, input bit m);
        in_valid = v;
        sel      = s;
        in_data  = d;
        mode     = m;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send(1'b0, 3'd0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        sel       = 3'd0;
        mode      = 1'b0;
        out_ready = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) begin
                mv[i][k] = 0;
                md[i][k] = 8'h00;
            end
            mptr[i] = 0;
            merr[i] = 0;
        end
        @(posedge clk);
        #1;
        do_reset();
        check("reset_valid8", 64'(out_valid8), 64'h0);

        // Addressed sweep, all consumers ready.
        for (int k = 0; k < 8; k++) send(1'b1, 3'(k), 8'(8'hA0 + k), 1'b0);
        send(1'b0, 3'd0, 8'h00, 1'b0);

        // Backpressure on channel 3.
        out_ready = 8'hF7;
        send(1'b1, 3'd3, 8'h11, 1'b0);
        send(1'b1, 3'd3, 8'h22, 1'b0);
        send(1'b1, 3'd3, 8'h22, 1'b0);
        check("bp_hold", 64'(out_data8[31:24]), 64'h11);
        out_ready = 8'hFF;
        send(1'b1, 3'd3, 8'h22, 1'b0);
        check("bp_refill_data",  64'(out_data8[31:24]), 64'h22);
        check("bp_refill_valid", 64'(out_valid8[3]), 64'h1);

        // Independence: channel 3 stalled full, channel 5 still flows.
        out_ready = 8'hF7;
        send(1'b1, 3'd3, 8'h33, 1'b0);
        send(1'b1, 3'd5, 8'h55, 1'b0);
        check("indep_valid5", 64'(out_valid8[5]), 64'h1);
        check("indep_data5",  64'(out_data8[47:40]), 64'h55);

        // Round-robin, then switch back to addressed.
        out_ready = 8'hFF;
        for (int k = 0; k < 10; k++) send(1'b1, 3'd0, 8'(k), 1'b1);
        send(1'b1, 3'd1, 8'h77, 1'b0);
        check("rr_hold", 64'(rr_ptr8), 64'h2);

        // Out-of-range selects on the N=6 instance.
        do_reset();
        send(1'b1, 3'd6, 8'hE6, 1'b0);
        send(1'b1, 3'd7, 8'hE7, 1'b0);
        check("oor_err2",   64'(err6), 64'h2);
        check("oor_nochan", 64'(out_valid6), 64'h0);
        for (int k = 0; k < 300; k++) send(1'b1, 3'(6 + (k % 2)), 8'(k), 1'b0);
        check("oor_sat", 64'(err6), 64'hFF);

        // Reset mid-operation.
        do_reset();
        for (int k = 0; k < 3; k++) send(1'b1, 3'd0, 8'(8'hC0 + k), 1'b1);
        out_ready = 8'h00;
        send(1'b1, 3'd1, 8'hC1, 1'b0);
        send(1'b1, 3'd4, 8'hC4, 1'b0);
        check("pre_rst_ptr", 64'(rr_ptr8), 64'h3);
        rst = 1'b1;
        send(1'b1, 3'd2, 8'hDD, 1'b0);
        rst = 1'b0;
        check("rst_valid", 64'(out_valid8), 64'h0);
        check("rst_data",  64'(out_data8),  64'h0);
        check("rst_ptr",   64'(rr_ptr8),    64'h0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 249) == 0);
            out_ready = 8'($urandom);
            send(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
